// File: rtl/dense_argmax.sv
// Frame-level argmax over N_CLASS signed logits with error accounting and a
// committed score bank that only ever holds the last good frame.
module dense_argmax #(
    parameter int N_CLASS = 11,
    parameter int DW      = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    din,
    input  logic             din_valid,
    output logic [IDX_W-1:0] class_idx,
    output logic [DW-1:0]    max_score,
    output logic             result_valid,
    output logic             frame_err,
    output logic [7:0]       err_cnt,
    output logic [15:0]      frame_cnt,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [DW-1:0]    rd_data
);

    localparam int CW = IDX_W + 1;
    localparam logic [CW-1:0] N_FULL = CW'(N_CLASS);

    typedef enum logic [1:0] {IDLE, ACC, OVER} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    run_max_q, run_max_d;
    logic [IDX_W-1:0] run_idx_q, run_idx_d;
    logic [DW-1:0]    shadow_q [N_CLASS];
    logic [DW-1:0]    shadow_d [N_CLASS];
    logic [DW-1:0]    committed_q [N_CLASS];
    logic [DW-1:0]    committed_d [N_CLASS];
    logic [IDX_W-1:0] class_idx_q, class_idx_d;
    logic [DW-1:0]    max_score_q, max_score_d;
    logic             result_valid_q, result_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [DW-1:0]    rd_data_q, rd_data_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        run_max_d      = run_max_q;
        run_idx_d      = run_idx_q;
        shadow_d       = shadow_q;
        committed_d    = committed_q;
        class_idx_d    = class_idx_q;
        max_score_d    = max_score_q;
        result_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        err_cnt_d      = err_cnt_q;
        frame_cnt_d    = frame_cnt_q;

        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    shadow_d[0] = din;
                    run_max_d   = din;
                    run_idx_d   = '0;
                    cnt_d       = CW'(1);
                    state_d     = ACC;
                end
            end
            ACC: begin
                if (din_valid) begin
                    if (cnt_q == N_FULL) begin
                        state_d = OVER;
                    end else begin
                        shadow_d[cnt_q[IDX_W-1:0]] = din;
                        // Strict greater-than keeps the lowest index on ties
                        if ($signed(din) > $signed(run_max_q)) begin
                            run_max_d = din;
                            run_idx_d = cnt_q[IDX_W-1:0];
                        end
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = IDLE;
                    if (cnt_q == N_FULL) begin
                        committed_d    = shadow_q;
                        class_idx_d    = run_idx_q;
                        max_score_d    = run_max_q;
                        result_valid_d = 1'b1;
                        frame_cnt_d    = frame_cnt_q + 16'd1;
                    end else begin
                        frame_err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            OVER: begin
                if (!din_valid) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Readback sees the bank before any commit happening on the same edge
    always_comb begin
        rd_data_d = '0;
        if ({1'b0, rd_addr} < N_FULL) rd_data_d = committed_q[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            run_max_q      <= '0;
            run_idx_q      <= '0;
            for (int i = 0; i < N_CLASS; i++) begin
                shadow_q[i]    <= '0;
                committed_q[i] <= '0;
            end
            class_idx_q    <= '0;
            max_score_q    <= '0;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            err_cnt_q      <= '0;
            frame_cnt_q    <= '0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            run_max_q      <= run_max_d;
            run_idx_q      <= run_idx_d;
            shadow_q       <= shadow_d;
            committed_q    <= committed_d;
            class_idx_q    <= class_idx_d;
            max_score_q    <= max_score_d;
            result_valid_q <= result_valid_d;
            frame_err_q    <= frame_err_d;
            err_cnt_q      <= err_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign class_idx    = class_idx_q;
    assign max_score    = max_score_q;
    assign result_valid = result_valid_q;
    assign frame_err    = frame_err_q;
    assign err_cnt      = err_cnt_q;
    assign frame_cnt    = frame_cnt_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_dense_argmax.sv
// Scoreboard bench for dense_argmax: stimulus pushes expected results, a
// negedge monitor pops and compares whenever a pulse appears.
module tb_dense_argmax;

    localparam int N = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [3:0]  class_idx;
    logic [15:0] max_score;
    logic        result_valid;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic [15:0] frame_cnt;
    logic [15:0] rd_data;

    dense_argmax #(.N_CLASS(N), .DW(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .class_idx(class_idx), .max_score(max_score),
        .result_valid(result_valid), .frame_err(frame_err),
        .err_cnt(err_cnt), .frame_cnt(frame_cnt),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [3:0]  idx;
        logic [15:0] score;
        logic [15:0] fcnt;
        logic [7:0]  ecnt;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int n_checks = 0;
    int n_fail = 0;
    int last_pulse = 0;
    int prev_pulse = 0;

    logic [3:0]  m_idx = '0;
    logic [15:0] m_score = '0;
    logic [15:0] m_fcnt = '0;
    logic [7:0]  m_ecnt = '0;

    logic [15:0] f_ramp [16];
    logic [15:0] f_tie  [16];
    logic [15:0] f_neg  [16];
    logic [15:0] f_desc [16];
    logic [15:0] f_big  [16];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives n contiguous samples plus one terminating low cycle
    task automatic applyStimulus(input int n, input logic [15:0] v [16],
                                 input logic [3:0] eidx, input logic [15:0] escore);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din_valid = 1'b1;
            din = v[i];
        end
        @(negedge clk);
        din_valid = 1'b0;
        din = '0;
        if (n == N) begin
            m_idx = eidx;
            m_score = escore;
            m_fcnt = m_fcnt + 16'd1;
        end else if (m_ecnt != 8'hFF) begin
            m_ecnt = m_ecnt + 8'd1;
        end
        e = '{err: (n != N), idx: m_idx, score: m_score, fcnt: m_fcnt, ecnt: m_ecnt, cyc: cyc + 1};
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("drain", sb.size(), 0);
    endtask

    task automatic read_check(input logic [3:0] a, input logic [15:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        checkOutput($sformatf("rd_data[%0d]", a), rd_data, exp);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_class_idx"}, class_idx, 0);
        checkOutput({tag, "_max_score"}, max_score, 0);
        checkOutput({tag, "_result_valid"}, result_valid, 0);
        checkOutput({tag, "_frame_err"}, frame_err, 0);
        checkOutput({tag, "_err_cnt"}, err_cnt, 0);
        checkOutput({tag, "_frame_cnt"}, frame_cnt, 0);
        checkOutput({tag, "_rd_data"}, rd_data, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (result_valid && frame_err) checkOutput("pulse_exclusive", 1, 0);
            if (result_valid || frame_err) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_pulse", 0, 1);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("pulse_kind_err", frame_err, mon_e.err);
                    checkOutput("class_idx", class_idx, mon_e.idx);
                    checkOutput("max_score", max_score, mon_e.score);
                    checkOutput("frame_cnt", frame_cnt, mon_e.fcnt);
                    checkOutput("err_cnt", err_cnt, mon_e.ecnt);
                    checkOutput("latency_cycle", cyc, mon_e.cyc);
                    if (result_valid) begin
                        prev_pulse = last_pulse;
                        last_pulse = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            f_ramp[i] = 16'((i + 1) * 16'h0100);
            f_tie[i]  = (i == 3 || i == 7) ? 16'h1000 : 16'hF000;
            f_neg[i]  = (i == 5) ? 16'hFFFF : ((i == 0) ? 16'hF000 : 16'hC000);
            f_desc[i] = 16'(16'h7000 - i * 16'h0100);
            f_big[i]  = 16'h7FFF;
        end

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(N, f_ramp, 4'd10, 16'h0B00);
        applyStimulus(N, f_tie, 4'd3, 16'h1000);
        applyStimulus(N, f_neg, 4'd5, 16'hFFFF);
        drain();
        read_check(4'd10, 16'hC000);

        applyStimulus(7, f_big, 4'd0, 16'h0);
        drain();
        read_check(4'd10, 16'hC000);
        read_check(4'd5, 16'hFFFF);
        applyStimulus(14, f_big, 4'd0, 16'h0);
        applyStimulus(N, f_ramp, 4'd10, 16'h0B00);
        drain();

        // Reset in the middle of a frame discards it silently
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            din_valid = 1'b1;
            din = f_big[i];
        end
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        #1;
        check_all_zero("midreset");
        sb.delete();
        m_idx = '0;
        m_score = '0;
        m_fcnt = '0;
        m_ecnt = '0;
        repeat (2) @(negedge clk);
        checkOutput("midreset_no_pulse", {result_valid, frame_err}, 0);
        rst = 1'b0;

        applyStimulus(N, f_ramp, 4'd10, 16'h0B00);
        applyStimulus(N, f_tie, 4'd3, 16'h1000);
        applyStimulus(N, f_desc, 4'd0, 16'h7000);
        drain();
        checkOutput("b2b_spacing", last_pulse - prev_pulse, 12);
        checkOutput("b2b_frame_cnt", frame_cnt, 3);
        for (int a = 0; a < N; a++) read_check(4'(a), f_desc[a]);
        read_check(4'd12, 16'h0000);

        for (int k = 0; k < 300; k++) applyStimulus(1, f_big, 4'd0, 16'h0);
        drain();
        checkOutput("err_cnt_saturated", err_cnt, 255);
        checkOutput("frame_cnt_after_errs", frame_cnt, 3);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
